// File: rtl/inst_pipe_regs.sv
// Instruction/PC pipeline register chain (D, E, M, W) with stall hold, flush bubbles,
// fetch PC write enable and retire pulse. Optional perf counters: INST_PIPE_PERF_CNT_EN.
//
// state  | meaning
// VALID  | stage register holds a real instruction
// BUBBLE | stage register holds NOP_INST injected by flush, stall or empty fetch
module inst_pipe_regs #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            fetch_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [31:0]     instF,
  output logic [31:0]     instD,
  output logic [31:0]     instE,
  output logic [31:0]     instM,
  output logic [31:0]     instW,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] pcM,
  output logic [XLEN-1:0] pcW,
  output logic            vD,
  output logic            vE,
  output logic            vM,
  output logic            vW,
`ifdef INST_PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] cnt_retired,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
`endif
  output logic            pc_we,
  output logic            retire
);

  typedef enum logic {
    BUBBLE = 1'b0,
    VALID  = 1'b1
  } stage_state_e;

  stage_state_e st_d, st_e, st_m, st_w;
  stage_state_e st_d_nxt, st_e_nxt, st_m_nxt, st_w_nxt;

  logic [31:0]     inst_d_nxt, inst_e_nxt, inst_m_nxt, inst_w_nxt;
  logic [XLEN-1:0] pc_d_nxt, pc_e_nxt, pc_m_nxt, pc_w_nxt;

  assign instF  = fetch_valid ? inst_in : NOP_INST;
  assign pc_we  = flush | ~stall;
  assign vD     = (st_d == VALID);
  assign vE     = (st_e == VALID);
  assign vM     = (st_m == VALID);
  assign vW     = (st_w == VALID);
  assign retire = vW;

  always_comb begin
    inst_d_nxt = instD;
    pc_d_nxt   = pcD;
    st_d_nxt   = st_d;
    inst_e_nxt = instE;
    pc_e_nxt   = pcE;
    st_e_nxt   = st_e;
    // M and W always advance; only D and E depend on flush/stall
    inst_m_nxt = instE;
    pc_m_nxt   = pcE;
    st_m_nxt   = st_e;
    inst_w_nxt = instM;
    pc_w_nxt   = pcM;
    st_w_nxt   = st_m;

    if (flush) begin
      inst_d_nxt = NOP_INST;
      st_d_nxt   = BUBBLE;
      inst_e_nxt = NOP_INST;
      st_e_nxt   = BUBBLE;
    end else if (stall) begin
      inst_e_nxt = NOP_INST;
      st_e_nxt   = BUBBLE;
    end else begin
      inst_d_nxt = instF;
      pc_d_nxt   = pc_in;
      st_d_nxt   = fetch_valid ? VALID : BUBBLE;
      inst_e_nxt = instD;
      pc_e_nxt   = pcD;
      st_e_nxt   = st_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instD <= NOP_INST;
      instE <= NOP_INST;
      instM <= NOP_INST;
      instW <= NOP_INST;
      pcD   <= '0;
      pcE   <= '0;
      pcM   <= '0;
      pcW   <= '0;
      st_d  <= BUBBLE;
      st_e  <= BUBBLE;
      st_m  <= BUBBLE;
      st_w  <= BUBBLE;
    end else begin
      instD <= inst_d_nxt;
      instE <= inst_e_nxt;
      instM <= inst_m_nxt;
      instW <= inst_w_nxt;
      pcD   <= pc_d_nxt;
      pcE   <= pc_e_nxt;
      pcM   <= pc_m_nxt;
      pcW   <= pc_w_nxt;
      st_d  <= st_d_nxt;
      st_e  <= st_e_nxt;
      st_m  <= st_m_nxt;
      st_w  <= st_w_nxt;
    end
  end

`ifdef INST_PIPE_PERF_CNT_EN
  // saturate at all-ones rather than wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_retired <= '0;
      cnt_stall   <= '0;
      cnt_flush   <= '0;
    end else begin
      if (vW && (cnt_retired != '1))
        cnt_retired <= cnt_retired + 1'b1;
      if (stall && !flush && (cnt_stall != '1))
        cnt_stall <= cnt_stall + 1'b1;
      if (flush && (cnt_flush != '1))
        cnt_flush <= cnt_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_pipe_regs.sv
// Directed self-checking bench for inst_pipe_regs: reset, streaming, stall, flush,
// fetch gaps and asynchronous reset; counter checks when INST_PIPE_PERF_CNT_EN is defined.
module tb_inst_pipe_regs;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst;
  logic [31:0] inst_in, pc_in;
  logic        fetch_valid, stall, flush;
  logic [31:0] instF, instD, instE, instM, instW;
  logic [31:0] pcD, pcE, pcM, pcW;
  logic        vD, vE, vM, vW, pc_we, retire;
`ifdef INST_PIPE_PERF_CNT_EN
  logic [31:0] cnt_retired, cnt_stall, cnt_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  inst_pipe_regs dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in),
    .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
    .instF(instF), .instD(instD), .instE(instE), .instM(instM), .instW(instW),
    .pcD(pcD), .pcE(pcE), .pcM(pcM), .pcW(pcW),
    .vD(vD), .vE(vE), .vM(vM), .vW(vW),
`ifdef INST_PIPE_PERF_CNT_EN
    .cnt_retired(cnt_retired), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush),
`endif
    .pc_we(pc_we), .retire(retire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    inst_in = 32'h0; pc_in = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic feed(input logic [31:0] inst, input logic [31:0] pc);
    inst_in = inst; pc_in = pc; fetch_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    inst_in = 32'hcafef00d; pc_in = 32'h0;
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({instD, instE, instM, instW} !== {4{NOP}}) begin n_fail++; $display("FAIL reset_inst: got %h %h %h %h want all %h", instD, instE, instM, instW, NOP); end
    n_checks++; if ({pcD, pcE, pcM, pcW} !== 128'h0) begin n_fail++; $display("FAIL reset_pc: got %h %h %h %h want 0", pcD, pcE, pcM, pcW); end
    n_checks++; if ({vD, vE, vM, vW, retire} !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 00000", {vD, vE, vM, vW, retire}); end
    n_checks++; if (instF !== NOP) begin n_fail++; $display("FAIL instF_invalid: got %h want %h", instF, NOP); end
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL reset_pc_we: got %b want 1", pc_we); end
    fetch_valid = 1'b1;
    #1;
    n_checks++; if (instF !== 32'hcafef00d) begin n_fail++; $display("FAIL instF_valid: got %h want cafef00d", instF); end
    tick;
    n_checks++; if ({instD, vD} !== {NOP, 1'b0}) begin n_fail++; $display("FAIL reset_held_on_edge: got %h/%b want %h/0", instD, vD, NOP); end
`ifdef INST_PIPE_PERF_CNT_EN
    n_checks++; if ({cnt_retired, cnt_stall, cnt_flush} !== 96'h0) begin n_fail++; $display("FAIL reset_cnt: got %h %h %h want 0", cnt_retired, cnt_stall, cnt_flush); end
`endif
  endtask

  task automatic test_stream;
    logic [31:0] prog [4];
    prog = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h40208233};
    do_reset;
    for (int e = 1; e <= 8; e++) begin
      if (e <= 4) feed(prog[e-1], 32'(4 * (e - 1)));
      else begin
        inst_in = 32'hdeadbeef; fetch_valid = 1'b0;
        tick;
      end
      if (e == 1) begin
        n_checks++; if ({instD, pcD, vD, vE} !== {prog[0], 32'h0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stream_d1: got %h/%h/%b/%b want %h/0/1/0", instD, pcD, vD, vE, prog[0]); end
      end
      if (e < 4) begin
        n_checks++; if ({vW, retire} !== 2'b00) begin n_fail++; $display("FAIL stream_early_e%0d: vW/retire got %b%b want 00", e, vW, retire); end
      end else if (e <= 7) begin
        n_checks++; if ({retire, instW, pcW} !== {1'b1, prog[e-4], 32'(4 * (e - 4))}) begin n_fail++; $display("FAIL stream_w_e%0d: got %b/%h/%h want 1/%h/%h", e, retire, instW, pcW, prog[e-4], 4 * (e - 4)); end
      end else begin
        n_checks++; if ({retire, instW} !== {1'b0, NOP}) begin n_fail++; $display("FAIL stream_drain: got %b/%h want 0/%h", retire, instW, NOP); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    feed(32'h00002083, 32'h0);   // lw x1
    feed(32'h00100113, 32'h4);
    feed(32'h00108193, 32'h8);   // uses x1
    inst_in = 32'h00000213; pc_in = 32'hc; stall = 1'b1;
    #1;
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL stall_pc_we: got %b want 0", pc_we); end
    tick;
    n_checks++; if ({instD, pcD, vD} !== {32'h00108193, 32'h8, 1'b1}) begin n_fail++; $display("FAIL stall_d_hold: got %h/%h/%b want 00108193/8/1", instD, pcD, vD); end
    n_checks++; if ({instE, vE} !== {NOP, 1'b0}) begin n_fail++; $display("FAIL stall_e_bubble: got %h/%b want %h/0", instE, vE, NOP); end
    n_checks++; if (instM !== 32'h00100113) begin n_fail++; $display("FAIL stall_m_adv: got %h want 00100113", instM); end
    stall = 1'b0;
    tick;
    n_checks++; if ({instE, pcE, vE} !== {32'h00108193, 32'h8, 1'b1}) begin n_fail++; $display("FAIL stall_release_e: got %h/%h/%b want 00108193/8/1", instE, pcE, vE); end
    n_checks++; if ({instD, vM, instW} !== {32'h00000213, 1'b0, 32'h00100113}) begin n_fail++; $display("FAIL stall_release_rest: got %h/%b/%h want 00000213/0/00100113", instD, vM, instW); end
  endtask

  task automatic test_flush(input logic with_stall);
    do_reset;
    feed(32'h0300006f, 32'h10);  // jal
    feed(32'h00100093, 32'h14);
    inst_in = 32'h00200093; pc_in = 32'h18; flush = 1'b1; stall = with_stall;
    #1;
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL flush_pc_we(stall=%b): got %b want 1", with_stall, pc_we); end
    tick;
    n_checks++; if ({instM, pcM, vM} !== {32'h0300006f, 32'h10, 1'b1}) begin n_fail++; $display("FAIL flush_m(stall=%b): got %h/%h/%b want 0300006f/10/1", with_stall, instM, pcM, vM); end
    n_checks++; if ({instD, vD, instE, vE} !== {NOP, 1'b0, NOP, 1'b0}) begin n_fail++; $display("FAIL flush_bubbles(stall=%b): got %h/%b %h/%b want NOP/0 NOP/0", with_stall, instD, vD, instE, vE); end
    flush = 1'b0; stall = 1'b0; inst_in = 32'h00300193; pc_in = 32'h40;
    tick;
    n_checks++; if ({instD, pcD, vD} !== {32'h00300193, 32'h40, 1'b1}) begin n_fail++; $display("FAIL flush_target(stall=%b): got %h/%h/%b want 00300193/40/1", with_stall, instD, pcD, vD); end
    n_checks++; if ({instW, vM, vE} !== {32'h0300006f, 1'b0, 1'b0}) begin n_fail++; $display("FAIL flush_tail(stall=%b): got %h/%b/%b want 0300006f/0/0", with_stall, instW, vM, vE); end
  endtask

  task automatic test_fetch_gap;
    logic [4:0] exp_ret;
    exp_ret = 5'b11001;  // edges 4..8, LSB = edge 4
    do_reset;
    for (int e = 1; e <= 8; e++) begin
      case (e)
        1: feed(32'h00100093, 32'h0);
        4: feed(32'h00200113, 32'h4);
        5: feed(32'h00300193, 32'h8);
        default: begin
          inst_in = 32'hdeadbeef; pc_in = 32'h4; fetch_valid = 1'b0;
          tick;
        end
      endcase
      if (e == 2) begin
        n_checks++; if ({instD, vD} !== {NOP, 1'b0}) begin n_fail++; $display("FAIL gap_d_nop: got %h/%b want %h/0", instD, vD, NOP); end
      end
      if (e >= 4) begin
        n_checks++; if (retire !== exp_ret[e-4]) begin n_fail++; $display("FAIL gap_retire_e%0d: got %b want %b", e, retire, exp_ret[e-4]); end
      end
      if (e == 6) begin
        n_checks++; if ({instW, vW} !== {NOP, 1'b0}) begin n_fail++; $display("FAIL gap_w_bubble: got %h/%b want %h/0", instW, vW, NOP); end
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    feed(32'h00100093, 32'h20);
    feed(32'h00200113, 32'h24);
    feed(32'h00300193, 32'h28);
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({instD, instE, instM, instW} !== {4{NOP}}) begin n_fail++; $display("FAIL async_rst_inst: got %h %h %h %h want all %h", instD, instE, instM, instW, NOP); end
    n_checks++; if ({pcD, pcE, pcM, pcW} !== 128'h0) begin n_fail++; $display("FAIL async_rst_pc: got %h %h %h %h want 0", pcD, pcE, pcM, pcW); end
    n_checks++; if ({vD, vE, vM, vW} !== 4'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0000", {vD, vE, vM, vW}); end
`ifdef INST_PIPE_PERF_CNT_EN
    n_checks++; if ({cnt_retired, cnt_stall, cnt_flush} !== 96'h0) begin n_fail++; $display("FAIL async_rst_cnt: got %h %h %h want 0", cnt_retired, cnt_stall, cnt_flush); end
`endif
    #2 rst = 1'b0;
    feed(32'h00400213, 32'h2c);
    n_checks++; if ({instD, pcD, vD} !== {32'h00400213, 32'h2c, 1'b1}) begin n_fail++; $display("FAIL post_rst_run: got %h/%h/%b want 00400213/2c/1", instD, pcD, vD); end
    stall = 1'b1; inst_in = 32'h00500293; pc_in = 32'h30;
    for (int i = 0; i < 3; i++) tick;
    n_checks++; if ({instD, vD, vE, pc_we} !== {32'h00400213, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL b2b_stall: got %h/%b/%b/%b want 00400213/1/0/0", instD, vD, vE, pc_we); end
`ifdef INST_PIPE_PERF_CNT_EN
    n_checks++; if ({cnt_stall, cnt_flush, cnt_retired} !== {32'd3, 32'd0, 32'd0}) begin n_fail++; $display("FAIL cnt_after_stalls: got %0d/%0d/%0d want 3/0/0", cnt_stall, cnt_flush, cnt_retired); end
    flush = 1'b1;
    tick;
    flush = 1'b0; stall = 1'b0;
    n_checks++; if ({cnt_stall, cnt_flush} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL cnt_after_flush: got %0d/%0d want 3/1", cnt_stall, cnt_flush); end
`endif
    stall = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_flush(1'b0);
    test_flush(1'b1);
    test_fetch_gap;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
